mem_arbiter: RTL
================

# mem_arbiter

Shares one single-ported memory bus between the instruction-fetch port and the MEM-stage load/store port of the 5-stage RV32 pipeline. Requests are registered, one transaction is in flight at a time, and each transaction completes with a registered acknowledge to its owner. Per-port stall outputs let the hazard logic freeze the PC / IF-ID (instruction) or the whole pipeline (data) while a port waits. Arbitration gives data priority but alternates when both ports are pending, so neither port starves.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32 (`BITWIDTH`): data width.
- `TIMEOUT_CYCLES`, 255: busy cycles without `bus_ack` before abort. Used only with `MEMARB_TIMEOUT_EN`.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `i_req` input 1: instruction read request. Held stable until `i_ack`.
- `i_addr` input ADDR_W: fetch address.
- `i_ack` output 1: one-cycle pulse, instruction transaction done.
- `i_rdata` output DATA_W: fetched word. Valid while `i_ack`.
- `i_err` output 1: transaction aborted. Valid while `i_ack`.
- `i_stall` output 1: `i_req & ~i_ack`.
- `d_req` input 1: data request. Held stable until `d_ack`.
- `d_we` input 1: 1 = store, 0 = load.
- `d_addr` input ADDR_W: load/store address.
- `d_wdata` input DATA_W: store data.
- `d_wstrb` input DATA_W/8: byte strobes.
- `d_ack`, `d_rdata`, `d_err`, `d_stall`: outputs, same semantics as the instruction port.
- `bus_req` output 1: memory request. Held until `bus_ack`.
- `bus_we`, `bus_addr`, `bus_wdata`, `bus_wstrb`: outputs, registered transaction fields.
- `bus_ack` input 1: memory completes the transaction this cycle.
- `bus_rdata` input DATA_W: read data. Valid with `bus_ack`.

## Operation
- FSM states:
  - IDLE
  - BUSY_I
  - BUSY_D
  - DONE: one cycle; drives the requester ack.
- IDLE grant rule:
  - Only `d_req` pending → BUSY_D.
  - Only `i_req` pending → BUSY_I.
  - Both pending → the port that was NOT granted last (`last_d` flag); the grant updates `last_d`.
- On grant: capture address, `we`, `wdata`, `wstrb` into bus registers. An instruction grant drives `we` = 0 and `wstrb` = 0.
- BUSY_x: `bus_req` = 1. On `bus_ack`:
  - capture `bus_rdata` (forced to 0 for stores);
  - drop `bus_req` on the next edge;
  - go to DONE.
- DONE: pulse the owner's ack with captured rdata, err = 0, then go to IDLE. Re-grant is possible on the following cycle.
- `bus_ack` in IDLE or DONE: ignored.
- Requester drops req mid-transaction (protocol violation): the transaction still completes and the ack still pulses.
- Reset values:
  - state IDLE; `last_d` = 0, so data wins the first tie;
  - all outputs 0, including `bus_*`, acks, rdata and err;
  - stalls follow their combinational definitions.
- Reset mid-transaction: `bus_req` is 0 from the next edge, and the pending ack is discarded. The memory must tolerate an abandoned request.

## Timing
- Request seen in IDLE at cycle 0 → `bus_req` = 1 from cycle 1.
- Zero-wait memory (`bus_ack` at cycle 1) → owner ack at cycle 2, and `bus_req` = 0 at cycle 2.
- Minimum latency: 2 cycles. Each memory wait cycle adds 1.
- Back-to-back throughput: one transaction per 3 cycles (grant, bus, done) with zero-wait memory.
- Stall outputs are combinational from req/ack, with no added register.

## Configuration
- `MEMARB_TIMEOUT_EN` defined:
  - an 8-bit counter clears on grant and increments each BUSY cycle without `bus_ack`;
  - on reaching `TIMEOUT_CYCLES`, the arbiter drops `bus_req`, enters DONE, and pulses the owner's ack with err = 1 and rdata = 0;
  - if `bus_ack` arrives in the same cycle as the limit, `bus_ack` wins (normal completion).
- Not defined: the arbiter waits indefinitely, `i_err`/`d_err` are tied to 0, and no counter is instantiated.

## Structure
- `defines.v` holds:
  - state encodings `MEMARB_IDLE`, `MEMARB_BUSY_I`, `MEMARB_BUSY_D`, `MEMARB_DONE` (2-bit);
  - the timeout counter width constant.
- One sub-module, `memarb_timer`: load/increment/limit-compare counter, instantiated only under `MEMARB_TIMEOUT_EN`.

## Test plan
- Single fetch: `i_req` with `i_addr` = 0x100, memory acks in the same cycle as `bus_req` with 0x00000013 → `bus_addr` = 0x100 at cycle 1, `i_ack` and `i_rdata` = 0x00000013 at cycle 2, `i_stall` high for cycles 0–1.
- Simultaneous requests: `i_req` (0x200) and `d_req` load (0x8000) at cycle 0 → data granted first (`bus_addr` = 0x8000, `bus_we` = 0), `d_ack` at cycle 2; then instruction granted, `i_ack` at cycle 5.
- Fairness: both ports held pending for 4 transactions → grants alternate D, I, D, I.
- Store with waits: `d_we` = 1, 0x8004, `wdata` 0xDEADBEEF, `wstrb` 0b0011, memory acks after 3 wait cycles → `bus_wstrb` = 0b0011 throughout, `d_ack` at cycle 5, `d_rdata` = 0.
- Reset mid-transaction: `rst` in cycle 2 of BUSY_D → `bus_req` = 0 and state IDLE at the next edge, and no `d_ack` ever pulses.
- Timeout (with `MEMARB_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 4, no `bus_ack`) → `d_ack` with `d_err` = 1 and `d_rdata` = 0. A retry with a prompt ack then completes with err = 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory bus arbiter.
// Replaces the old defines.v state encodings and timer-width macro.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        MEMARB_IDLE   = 2'd0,
        MEMARB_BUSY_I = 2'd1,
        MEMARB_BUSY_D = 2'd2,
        MEMARB_DONE   = 2'd3
    } memarb_state_t;

    localparam int unsigned MEMARB_TIMER_W = 8;

endpackage

// File: rtl/mem_arbiter_timer.sv
// Bus timeout counter: clears on grant, counts ack-less busy cycles and flags
// the cycle on which the limit is reached. Used only with MEMARB_TIMEOUT_EN.
module memarb_timer
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned W     = MEMARB_TIMER_W,
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic inc,
    output logic expired
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

    // Fires on the LIMIT-th busy cycle without an ack, so the abort is taken
    // on that same edge.
    assign expired = inc && (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Instruction-fetch / load-store arbiter for one single-ported memory bus.
// Optional bus timeout with abort is enabled by defining MEMARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ack,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_err,
    output logic                i_stall,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_err,
    output logic                d_stall,

    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_wstrb,
    input  logic                bus_ack,
    input  logic [DATA_W-1:0]   bus_rdata
);

    memarb_state_t state, state_n;
    logic          last_d;
    logic          grant_i, grant_d;
    logic          complete, abort;
    logic          timeout;

    assign i_stall = i_req & ~i_ack;
    assign d_stall = d_req & ~d_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MEMARB_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        complete = 1'b0;
        abort    = 1'b0;
        case (state)
            MEMARB_IDLE: begin
                // On a tie, data wins unless it was the last port served.
                if (d_req && !(i_req && last_d)) begin
                    grant_d = 1'b1;
                    state_n = MEMARB_BUSY_D;
                end else if (i_req) begin
                    grant_i = 1'b1;
                    state_n = MEMARB_BUSY_I;
                end
            end
            MEMARB_BUSY_I, MEMARB_BUSY_D: begin
                if (bus_ack) begin
                    complete = 1'b1;
                    state_n  = MEMARB_DONE;
                end else if (timeout) begin
                    abort   = 1'b1;
                    state_n = MEMARB_DONE;
                end
            end
            MEMARB_DONE: state_n = MEMARB_IDLE;
            default:     state_n = MEMARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_d    <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wstrb <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            if (grant_d) begin
                last_d    <= 1'b1;
                bus_req   <= 1'b1;
                bus_we    <= d_we;
                bus_addr  <= d_addr;
                bus_wdata <= d_wdata;
                bus_wstrb <= d_wstrb;
            end else if (grant_i) begin
                last_d    <= 1'b0;
                bus_req   <= 1'b1;
                bus_we    <= 1'b0;
                bus_addr  <= i_addr;
                bus_wdata <= '0;
                bus_wstrb <= '0;
            end
            if (complete || abort) begin
                bus_req <= 1'b0;
                if (state == MEMARB_BUSY_D) begin
                    d_ack   <= 1'b1;
                    d_rdata <= (complete && !bus_we) ? bus_rdata : '0;
                end else begin
                    i_ack   <= 1'b1;
                    i_rdata <= complete ? bus_rdata : '0;
                end
            end
        end
    end

`ifdef MEMARB_TIMEOUT_EN
    logic busy;

    assign busy = (state == MEMARB_BUSY_I) || (state == MEMARB_BUSY_D);

    memarb_timer #(
        .W     (MEMARB_TIMER_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (grant_i | grant_d),
        .inc     (busy & ~bus_ack),
        .expired (timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            i_err <= 1'b0;
            d_err <= 1'b0;
        end else begin
            i_err <= abort && (state == MEMARB_BUSY_I);
            d_err <= abort && (state == MEMARB_BUSY_D);
        end
    end
`else
    assign timeout = 1'b0;
    assign i_err   = 1'b0;
    assign d_err   = 1'b0;
`endif

endmodule
